// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// using a single full-subtract cell with a registered borrow. start/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_sh;
  logic             bflop;
  logic [CW-1:0]    cnt;

  logic             cell_d;
  logic             cell_bo;

  // Full-subtract cell on the current LSBs with the registered borrow-in
  always_comb begin
    cell_d  = sa[0] ^ sb[0] ^ bflop;
    cell_bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bflop);
  end

  // New difference bit enters at the MSB as the result shifts right
  always_comb begin
    res_sh            = res >> 1;
    res_sh[WIDTH-1]   = cell_d;
  end

  assign last = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      bflop <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      borr  <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      if (load) begin
        sa    <= a;
        sb    <= b;
        res   <= '0;
        bflop <= 1'b0;
        cnt   <= '0;
      end else if (step) begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        res   <= res_sh;
        bflop <= cell_bo;
        cnt   <= cnt + CW'(1);
        if (last) begin
          diff <= res_sh;
          borr <= cell_bo;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borr8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borr1;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borr(borr8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borr(borr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full WIDTH=8 operation with latency, busy-length and result checks
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb);
    int n;
    int bc;
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n  = 0;
    bc = busy8 ? 1 : 0;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
      bc = bc + (busy8 ? 1 : 0);
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_busycycles"}, bc, 9);
    check({tag, "_diff"}, diff8, ed);
    check({tag, "_borr"}, borr8, eb);
    tick();
    check({tag, "_done_drop"}, done8, 0);
    check({tag, "_busy_drop"}, busy8, 0);
  endtask

  logic [7:0] va [4];
  logic [7:0] vb [4];
  logic [7:0] vd [4];
  logic       vbo[4];

  initial begin
    int n;
    int extra;
    int k;

    va[0] = 8'd100; vb[0] = 8'd37;  vd[0] = 8'd63;  vbo[0] = 1'b0;
    va[1] = 8'h00;  vb[1] = 8'h01;  vd[1] = 8'hFF;  vbo[1] = 1'b1;
    va[2] = 8'hA5;  vb[2] = 8'hA5;  vd[2] = 8'h00;  vbo[2] = 1'b0;
    va[3] = 8'hFF;  vb[3] = 8'h00;  vd[3] = 8'hFF;  vbo[3] = 1'b0;

    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd1;
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    tick();
    tick();
    // reset overrides start
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_borr", borr8, 0);
    check("rst_busy_w1", busy1, 0);
    start8 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    tick();

    op8("t1", 8'd100, 8'd37, 8'd63, 1'b0);
    op8("t2a", 8'h00, 8'h01, 8'hFF, 1'b1);
    op8("t2b", 8'hA5, 8'hA5, 8'h00, 1'b0);
    op8("t2c", 8'hFF, 8'h00, 8'hFF, 1'b0);

    // start pulsed mid-operation must be ignored
    a8 = 8'd100; b8 = 8'd37; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    a8 = 8'd5; b8 = 8'd9; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 4;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("t3_latency", n, 8);
    check("t3_diff", diff8, 8'd63);
    check("t3_borr", borr8, 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 === 1'b1 || busy8 === 1'b1) extra++;
    end
    check("t3_no_extra", extra, 0);

    // reset mid-shift aborts
    a8 = 8'd10; b8 = 8'd20; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t4_busy", busy8, 0);
    check("t4_done", done8, 0);
    check("t4_diff", diff8, 0);
    check("t4_borr", borr8, 0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done8 === 1'b1) extra++;
    end
    check("t4_no_done", extra, 0);
    op8("t4_after", 8'd200, 8'd55, 8'd145, 1'b0);

    // start held high: accepts every 10 cycles, a/b changed just after each accept
    a8 = va[0]; b8 = vb[0]; start8 = 1'b1;
    tick();
    for (int t = 1; t < 40; t++) begin
      if (t % 10 == 1 && t / 10 + 1 < 4) begin
        a8 = va[t / 10 + 1];
        b8 = vb[t / 10 + 1];
      end
      if (t == 31) start8 = 1'b0;
      tick();
      check($sformatf("t5_done_t%0d", t), done8, (t % 10 == 8) ? 1 : 0);
      if (t % 10 == 8) begin
        k = t / 10;
        check($sformatf("t5_diff_op%0d", k), diff8, vd[k]);
        check($sformatf("t5_borr_op%0d", k), borr8, vbo[k]);
      end
    end

    // WIDTH=1: half-subtractor truth table, done one edge after accept
    for (int v = 0; v < 4; v++) begin
      a1 = 1'(v >> 1);
      b1 = 1'(v);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check($sformatf("t6_busy_%0d", v), busy1, 1);
      tick();
      check($sformatf("t6_done_%0d", v), done1, 1);
      check($sformatf("t6_diff_%0d", v), diff1, (v == 1 || v == 2) ? 1 : 0);
      check($sformatf("t6_borr_%0d", v), borr1, (v == 1) ? 1 : 0);
      tick();
      check($sformatf("t6_idle_%0d", v), done1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
